// File: rtl/key_sched_pkg.sv
// Shared DES key-schedule tables, FSM state type and rotation helpers.
package key_sched_pkg;

  localparam int unsigned KEY_W      = 64;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned RK_W       = 48;
  localparam int unsigned MAX_ROUNDS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // PC-1: entry j names the DES key bit (1 = MSB) feeding C||D bit j+1.
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry j names the C||D bit (1 = MSB) feeding round-key bit j+1.
  localparam int unsigned PC2_TAB [RK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount per round, rounds 1..16 at indices 0..15.
  localparam int unsigned SHIFT_TAB [MAX_ROUNDS] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Shift for a 1-based round number; out-of-range rounds give 0.
  function automatic int unsigned shift_of(input int unsigned rnd);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < MAX_ROUNDS; i++) begin
      if (rnd == i + 1) s = SHIFT_TAB[4'(i)];
    end
    return s;
  endfunction

  // Cumulative rotation after n rounds, reduced modulo the half width.
  function automatic int unsigned total_shift(input int unsigned n);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < MAX_ROUNDS; i++) begin
      if (i < n) s = s + SHIFT_TAB[4'(i)];
    end
    return s % HALF_W;
  endfunction

  // 28-bit rotate left by s (s < 28).
  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int unsigned s);
    logic [2*HALF_W-1:0] t;
    t = {x, x} << s;
    return t[2*HALF_W-1:HALF_W];
  endfunction

  // 28-bit rotate right by s (s < 28).
  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input int unsigned s);
    logic [2*HALF_W-1:0] t;
    t = {x, x} >> s;
    return t[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Request/round-key stream bundle between a key consumer and the scheduler.
interface key_schedule_seq_if
  import key_sched_pkg::*;
#(
  parameter int unsigned IDX_W = 5
);
  logic              start;
  logic [KEY_W-1:0]  key_in;
  logic              decrypt;
  logic              rk_ready;
  logic              rk_valid;
  logic [RK_W-1:0]   rk_data;
  logic [IDX_W-1:0]  rk_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, key_in, decrypt, rk_ready,
    input  rk_valid, rk_data, rk_idx, busy, done
  );

  modport slave (
    input  start, key_in, decrypt, rk_ready,
    output rk_valid, rk_data, rk_idx, busy, done
  );
endinterface

// File: rtl/key_pc2_perm.sv
// DES PC-2 compression: 56-bit C||D to 48-bit round key.
module key_pc2_perm
  import key_sched_pkg::*;
(
  input  logic [CD_W-1:0] cd,
  output logic [RK_W-1:0] rk_c
);

  // Pure bit selection; bit numbering is DES style with 1 = MSB.
  always_comb begin
    rk_c = '0;
    for (int unsigned j = 0; j < RK_W; j++) begin
      rk_c[6'(RK_W - 1 - j)] = cd[6'(CD_W - PC2_TAB[6'(j)])];
    end
  end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential DES key schedule: streams NUM_ROUNDS round keys per request,
// forward for encryption or reversed for decryption.
module key_schedule_seq
  import key_sched_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned IDX_W      = 5
)
(
  input logic              clk,
  input logic              rst_n,
  key_schedule_seq_if.slave bus
);

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ROUNDS);
  localparam int unsigned      DEC_SHIFT = total_shift(NUM_ROUNDS);

  state_t              state_q, state_nxt;
  logic [HALF_W-1:0]   c_q, d_q, c_nxt, d_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                mode_q, mode_nxt;
  logic                done_nxt;
  logic [CD_W-1:0]     pc1_c;
  logic [RK_W-1:0]     rk_c;
  logic                last_c;

  // PC-1 of the incoming key, parity bits dropped.
  always_comb begin
    pc1_c = '0;
    for (int unsigned j = 0; j < CD_W; j++) begin
      pc1_c[6'(CD_W - 1 - j)] = bus.key_in[6'(KEY_W - PC1_TAB[6'(j)])];
    end
  end

  assign last_c = mode_q ? (idx_q == IDX_FIRST) : (idx_q == IDX_LAST);

  // Next-state and next C/D/index; C/D always hold the halves for rk_idx.
  always_comb begin
    state_nxt = state_q;
    c_nxt     = c_q;
    d_nxt     = d_q;
    idx_nxt   = idx_q;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = EMIT;
          mode_nxt  = bus.decrypt;
          if (bus.decrypt) begin
            // Jump straight to the last round's halves.
            c_nxt   = rotl28(pc1_c[CD_W-1:HALF_W], DEC_SHIFT);
            d_nxt   = rotl28(pc1_c[HALF_W-1:0], DEC_SHIFT);
            idx_nxt = IDX_LAST;
          end else begin
            c_nxt   = rotl28(pc1_c[CD_W-1:HALF_W], shift_of(1));
            d_nxt   = rotl28(pc1_c[HALF_W-1:0], shift_of(1));
            idx_nxt = IDX_FIRST;
          end
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (last_c) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (mode_q) begin
            // Undo this round's rotation to step back one round.
            c_nxt   = rotr28(c_q, shift_of(32'(idx_q)));
            d_nxt   = rotr28(d_q, shift_of(32'(idx_q)));
            idx_nxt = idx_q - IDX_W'(1);
          end else begin
            c_nxt   = rotl28(c_q, shift_of(32'(idx_q) + 1));
            d_nxt   = rotl28(d_q, shift_of(32'(idx_q) + 1));
            idx_nxt = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round key of the halves that will be current next cycle.
  key_pc2_perm u_pc2 (
    .cd   ({c_nxt, d_nxt}),
    .rk_c (rk_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Schedule datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      d_q    <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      c_q    <= c_nxt;
      d_q    <= d_nxt;
      idx_q  <= idx_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Registered outputs, zeroed whenever no key is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rk_valid <= 1'b0;
      bus.rk_data  <= '0;
      bus.rk_idx   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.rk_valid <= (state_nxt == EMIT);
      bus.busy     <= (state_nxt == EMIT);
      bus.rk_data  <= (state_nxt == EMIT) ? rk_c : '0;
      bus.rk_idx   <= (state_nxt == EMIT) ? idx_nxt : '0;
      bus.done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq at 16 and 4 rounds.
module tb_key_schedule_seq;

  localparam logic [63:0] KNOWN_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [47:0] K1_KNOWN  = 48'h1B02_EFFC_7072;
  localparam logic [47:0] K16_KNOWN = 48'hCB3D_8B0E_17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        rk_ready;
  logic        sel;          // 0 = 16-round instance, 1 = 4-round instance

  int vectors;
  int miscompares;

  logic [47:0] first_data, last_data;
  logic [4:0]  first_idx, last_idx;

  key_schedule_seq_if #(.IDX_W(5)) bus16 ();
  key_schedule_seq_if #(.IDX_W(5)) bus4 ();

  assign bus16.start    = start && !sel;
  assign bus16.key_in   = key_in;
  assign bus16.decrypt  = decrypt;
  assign bus16.rk_ready = rk_ready;
  assign bus4.start     = start && sel;
  assign bus4.key_in    = key_in;
  assign bus4.decrypt   = decrypt;
  assign bus4.rk_ready  = rk_ready;

  key_schedule_seq #(.NUM_ROUNDS(16), .IDX_W(5)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  key_schedule_seq #(.NUM_ROUNDS(4), .IDX_W(5)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  logic        obs_valid, obs_busy, obs_done;
  logic [47:0] obs_data;
  logic [4:0]  obs_idx;
  assign obs_valid = sel ? bus4.rk_valid : bus16.rk_valid;
  assign obs_busy  = sel ? bus4.busy     : bus16.busy;
  assign obs_done  = sel ? bus4.done     : bus16.done;
  assign obs_data  = sel ? bus4.rk_data  : bus16.rk_data;
  assign obs_idx   = sel ? bus4.rk_idx   : bus16.rk_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: DES round key rnd built from PC-1 bits and the cumulative shift.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int rnd);
    bit          cd [1:56];
    logic [47:0] r;
    int          cum, p, src;
    cum = 0;
    for (int i = 0; i < rnd; i++) cum += SH[4'(i)];
    for (int j = 1; j <= 56; j++) cd[6'(j)] = k[6'(64 - PC1[6'(j - 1)])];
    r = '0;
    for (int j = 1; j <= 48; j++) begin
      p = PC2[6'(j - 1)];
      if (p <= 28) src = ((p - 1 + cum) % 28) + 1;
      else         src = ((p - 29 + cum) % 28) + 29;
      r[6'(48 - j)] = cd[6'(src)];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One whole schedule on the selected instance; entered and left on a negedge.
  task automatic run_sched(input int n, input logic [63:0] k, input logic dec,
                           input int rdy_pct, input bit poke, input bit started,
                           input bit chain, input logic [63:0] k2, input logic dec2);
    int          e, cyc, exp_i;
    bit          poked, stalled;
    logic [47:0] prev_data;
    logic [4:0]  prev_idx;
    poked   = 1'b0;
    stalled = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    if (!started) begin
      start = 1'b1; key_in = k; decrypt = dec; rk_ready = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    e = 0; cyc = 0;
    while (e < n && cyc < 400) begin
      exp_i = dec ? (n - e) : (e + 1);
      chk("valid", 64'(obs_valid), 64'(1));
      chk("busy", 64'(obs_busy), 64'(1));
      chk("done_mid", 64'(obs_done), 64'(0));
      chk("idx", 64'(obs_idx), 64'(exp_i));
      chk("data", 64'(obs_data), 64'(ref_key(k, exp_i)));
      if (stalled) begin
        chk("hold_data", 64'(obs_data), 64'(prev_data));
        chk("hold_idx", 64'(obs_idx), 64'(prev_idx));
      end
      if (e == 0) begin first_data = obs_data; first_idx = obs_idx; end
      last_data = obs_data; last_idx = obs_idx;
      prev_data = obs_data; prev_idx = obs_idx;
      if (poke && e == 2 && !poked) begin
        start = 1'b1; key_in = ~k; decrypt = ~dec; poked = 1'b1;
      end else begin
        start = 1'b0; key_in = {$urandom, $urandom}; decrypt = 1'($urandom_range(1));
      end
      rk_ready = ($urandom_range(99) < rdy_pct);
      stalled  = !rk_ready;
      if (rk_ready) e++;
      cyc++;
      @(negedge clk);
    end
    chk("key_count", 64'(e), 64'(n));
    chk("done_pulse", 64'(obs_done), 64'(1));
    chk("valid_end", 64'(obs_valid), 64'(0));
    chk("busy_end", 64'(obs_busy), 64'(0));
    chk("data_zero", 64'(obs_data), 64'(0));
    chk("idx_zero", 64'(obs_idx), 64'(0));
    rk_ready = 1'b0;
    if (chain) begin start = 1'b1; key_in = k2; decrypt = dec2; end
    else       start = 1'b0;
    @(negedge clk);
    chk("done_once", 64'(obs_done), 64'(0));
  endtask

  initial begin
    int          cyc;
    logic [63:0] rk1, rk2;
    vectors = 0; miscompares = 0;
    start = 1'b0; key_in = '0; decrypt = 1'b0; rk_ready = 1'b0; sel = 1'b0;
    first_data = '0; last_data = '0; first_idx = '0; last_idx = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid16", 64'(bus16.rk_valid), 64'(0));
    chk("rst_data16", 64'(bus16.rk_data), 64'(0));
    chk("rst_idx16", 64'(bus16.rk_idx), 64'(0));
    chk("rst_busy16", 64'(bus16.busy), 64'(0));
    chk("rst_done16", 64'(bus16.done), 64'(0));
    chk("rst_valid4", 64'(bus4.rk_valid), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", 64'(obs_valid), 64'(0));

    // Known-answer encrypt and decrypt, no backpressure.
    run_sched(16, KNOWN_KEY, 1'b0, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("enc_first_data", 64'(first_data), 64'(K1_KNOWN));
    chk("enc_first_idx", 64'(first_idx), 64'(1));
    chk("enc_last_data", 64'(last_data), 64'(K16_KNOWN));
    chk("enc_last_idx", 64'(last_idx), 64'(16));
    run_sched(16, KNOWN_KEY, 1'b1, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("dec_first_data", 64'(first_data), 64'(K16_KNOWN));
    chk("dec_first_idx", 64'(first_idx), 64'(16));
    chk("dec_last_data", 64'(last_data), 64'(K1_KNOWN));
    chk("dec_last_idx", 64'(last_idx), 64'(1));

    // Random keys under ~50% backpressure, both modes.
    for (int t = 0; t < 4; t++) begin
      rk1 = {$urandom, $urandom};
      run_sched(16, rk1, 1'(t), 50, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end

    // Start poked mid-schedule, then back-to-back start in the done cycle.
    rk1 = {$urandom, $urandom};
    rk2 = {$urandom, $urandom};
    run_sched(16, rk1, 1'b0, 70, 1'b1, 1'b0, 1'b1, rk2, 1'b1);
    run_sched(16, rk2, 1'b1, 100, 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Reset dropped mid-schedule at round 7.
    start = 1'b1; key_in = KNOWN_KEY; decrypt = 1'b0; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (obs_idx != 5'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx7", 64'(obs_idx), 64'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(obs_valid), 64'(0));
    chk("arst_data", 64'(obs_data), 64'(0));
    chk("arst_idx", 64'(obs_idx), 64'(0));
    chk("arst_busy", 64'(obs_busy), 64'(0));
    chk("arst_done", 64'(obs_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 64'(obs_done), 64'(0));
    chk("post_rst_valid", 64'(obs_valid), 64'(0));
    run_sched(16, KNOWN_KEY, 1'b0, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("post_rst_first", 64'(first_data), 64'(K1_KNOWN));
    chk("post_rst_idx", 64'(first_idx), 64'(1));

    // Four-round instance.
    sel = 1'b1;
    @(negedge clk);
    run_sched(4, KNOWN_KEY, 1'b0, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("n4_enc_first", 64'(first_data), 64'(K1_KNOWN));
    chk("n4_enc_last_idx", 64'(last_idx), 64'(4));
    run_sched(4, KNOWN_KEY, 1'b1, 100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("n4_dec_first_idx", 64'(first_idx), 64'(4));
    chk("n4_dec_last", 64'(last_data), 64'(K1_KNOWN));
    for (int t = 0; t < 4; t++) begin
      rk1 = {$urandom, $urandom};
      run_sched(4, rk1, 1'(t), 50, 1'(t == 1), 1'b0, 1'b0, '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
